// File: rtl/riscv_mem_wb.sv
// riscv_mem_wb: memory / writeback stage of a small in-order RISC-V pipeline.
// Non-memory results are written back one cycle after acceptance. Loads and
// stores run a req/ack handshake to data memory. Load data is lane-extracted
// and sign/zero extended before writeback. While an access is outstanding,
// in_ready is low, which stalls execute.
// Optional build macro: RISCV_MISALIGN_TRAP_EN adds a 'misalign' output and
// suppresses misaligned loads/stores instead of silently aligning them.
module riscv_mem_wb #(
    parameter int XLEN = 32,
    parameter int REGN = 32,
    parameter int REGA = $clog2(REGN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] result,
    input  logic [REGA-1:0] rd,
    input  logic            memfetch,
    input  logic            memstore,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      funct3,
`ifdef RISCV_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            wb_en,
    output logic [REGA-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t          state_r;
    logic            is_load_r;
    logic [2:0]      ld_f3_r;
    logic [1:0]      ld_off_r;
    logic [REGA-1:0] ld_rd_r;

    logic accept_s;
    logic mem_op_s;
    logic misalign_s;

    // Byte enables: byte lane = off, half lane = off[1], everything else a full word.
    function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb_v;
        case (f3[1:0])
            2'b00:   strb_v = 4'b0001 << off;
            2'b01:   strb_v = off[1] ? 4'b1100 : 4'b0011;
            default: strb_v = 4'b1111;
        endcase
        return strb_v;
    endfunction

    // Store data is replicated across lanes so the strobes alone select the bytes.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd_v;
        case (f3[1:0])
            2'b00:   wd_v = {4{sd[7:0]}};
            2'b01:   wd_v = {2{sd[15:0]}};
            default: wd_v = sd;
        endcase
        return wd_v;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'h000000, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b101:  res_v = {16'h0000, half_v};
            default: res_v = rdata;
        endcase
        return res_v;
    endfunction

    // Halfwords must be 2-byte aligned, words (and reserved sizes) 4-byte aligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis_v;
        case (f3[1:0])
            2'b00:   mis_v = 1'b0;
            2'b01:   mis_v = off[0];
            default: mis_v = (off != 2'b00);
        endcase
        return mis_v;
    endfunction

    assign in_ready = rst_n & (state_r == ST_IDLE);
    assign accept_s = in_valid & in_ready;
    assign mem_op_s = memfetch | memstore;
`ifdef RISCV_MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(funct3, result[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Stage sequencer: accept ops, drive the memory handshake, produce writebacks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            is_load_r <= 1'b0;
            ld_f3_r   <= 3'b000;
            ld_off_r  <= 2'b00;
            ld_rd_r   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
`ifdef RISCV_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            wb_en <= 1'b0;
`ifdef RISCV_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && mem_op_s) begin
                        if (misalign_s) begin
`ifdef RISCV_MISALIGN_TRAP_EN
                            misalign <= 1'b1;
`endif
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= memstore;
                            mem_addr  <= {result[XLEN-1:2], 2'b00};
                            mem_wdata <= lane_wdata(funct3, store_data);
                            mem_wstrb <= lane_strb(funct3, result[1:0]);
                            is_load_r <= memfetch;
                            ld_f3_r   <= funct3;
                            ld_off_r  <= result[1:0];
                            ld_rd_r   <= rd;
                            state_r   <= ST_MEM;
                        end
                    end else if (accept_s) begin
                        // x0 is hard-wired to zero, so its writes are dropped.
                        wb_en   <= (rd != '0);
                        wb_rd   <= rd;
                        wb_data <= result;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEM: begin
                    if (mem_ack && mem_req) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_load_r) begin
                            wb_en   <= (ld_rd_r != '0);
                            wb_rd   <= ld_rd_r;
                            wb_data <= load_extract(ld_f3_r, ld_off_r, mem_rdata);
                            state_r <= ST_WB;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WB: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_wb.sv
// Self-checking bench for riscv_mem_wb: reset, ALU writeback, a table of
// directed load/store vectors, reset during an access, the misaligned-address
// behaviour of the current build, and a randomized run against a
// transaction-level reference model.
module tb_riscv_mem_wb;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, memfetch, memstore;
    logic [31:0] result, store_data, mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [4:0]  rd, wb_rd;
    logic [2:0]  funct3;
    logic        mem_req, mem_we, mem_ack, wb_en;
    logic [3:0]  mem_wstrb;
`ifdef RISCV_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_mem_wb dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .rd(rd), .memfetch(memfetch), .memstore(memstore),
        .store_data(store_data), .funct3(funct3),
`ifdef RISCV_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_ready actual=%b expected=1 within 20 cycles", in_ready);
        end
    endtask

    // ---------------- reference model (arithmetic on access size) ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic int base_of(input logic [2:0] f3, input logic [31:0] addr);
        int s = size_of(f3);
        int off = int'(addr % 32'd4);
        return (off / s) * s;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        int s = size_of(f3);
        int v = ((1 << s) - 1) << base_of(f3, addr);
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int s = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v, mask;
        int s = size_of(f3);
        v = rdata >> (8 * base_of(f3, addr));
        if (s < 4) begin
            mask = (32'h1 << (8 * s)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*s-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rdi;
        int          delay;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        wait_ready();
        in_valid = 1'b1; memfetch = v.ld; memstore = !v.ld; funct3 = v.f3;
        result = v.res; store_data = v.sd; rd = v.rdi;
        @(posedge clk); #1;
        in_valid = 1'b0; memfetch = 1'b0; memstore = 1'b0;
        chk1("vec_req", mem_req, 1'b1);
        chk32("vec_addr", mem_addr, v.e_addr);
        chk1("vec_we", mem_we, !v.ld);
        chk32("vec_strb", {28'h0, mem_wstrb}, {28'h0, v.e_strb});
        if (!v.ld) chk32("vec_wdata", mem_wdata, v.e_wdata);
        chk1("vec_busy", in_ready, 1'b0);
        for (int k = 1; k < v.delay; k++) begin
            @(posedge clk); #1;
            chk1("vec_hold_req", mem_req, 1'b1);
            chk32("vec_hold_addr", mem_addr, v.e_addr);
            chk1("vec_hold_busy", in_ready, 1'b0);
            chk1("vec_hold_nowb", wb_en, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = v.rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk1("vec_req_drop", mem_req, 1'b0);
        chk1("vec_wb_en", wb_en, v.ld && (v.rdi != 5'd0));
        if (v.ld && v.rdi != 5'd0) begin
            chk32("vec_wb_rd", {27'h0, wb_rd}, {27'h0, v.rdi});
            chk32("vec_wb_data", wb_data, v.e_wb);
        end
        chk1("vec_ready_after", in_ready, !v.ld);
        if (v.ld) begin
            @(posedge clk); #1;
            chk1("vec_wb_once", wb_en, 1'b0);
            chk1("vec_ready_back", in_ready, 1'b1);
        end
    endtask

    // ---------------- random-run model state ----------------
    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rdi;
    } op_t;

    initial begin
        op_t         cur, nop;
        logic        req_e, rdy_e, v_s, ack_s, accept, wbcycle, req_n, rdy_n, wb_n;
        logic [4:0]  wbrd_n;
        logic [31:0] wbd_n, rdata_s;
        int          kind, cnt;
        vec_t        xv;

        vecs[0] = '{1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 5'd3, 3, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80};
        vecs[1] = '{1'b1, 3'b101, 32'h202, 32'h0, 32'hBEEF_1234, 5'd4, 1, 32'h200, 4'b1100, 32'h0, 32'h0000_BEEF};
        vecs[2] = '{1'b0, 3'b001, 32'h306, 32'hAAAA_5678, 32'h0, 5'd9, 2, 32'h304, 4'b1100, 32'h5678_5678, 32'h0};
        vecs[3] = '{1'b0, 3'b000, 32'h401, 32'h1234_56AB, 32'h0, 5'd1, 1, 32'h400, 4'b0010, 32'hABAB_ABAB, 32'h0};
        vecs[4] = '{1'b1, 3'b001, 32'h500, 32'h0, 32'h1234_8001, 5'd10, 1, 32'h500, 4'b0011, 32'h0, 32'hFFFF_8001};
        vecs[5] = '{1'b1, 3'b100, 32'h602, 32'h0, 32'h0080_0000, 5'd11, 4, 32'h600, 4'b0100, 32'h0, 32'h0000_0080};
        vecs[6] = '{1'b1, 3'b010, 32'h704, 32'h0, 32'hDEAD_BEEF, 5'd31, 1, 32'h704, 4'b1111, 32'h0, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 3'b010, 32'h808, 32'hCAFE_F00D, 32'h0, 5'd2, 2, 32'h808, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[8] = '{1'b1, 3'b000, 32'h900, 32'h0, 32'h0000_007F, 5'd0, 1, 32'h900, 4'b0001, 32'h0, 32'h0};

        rst_n = 1'b0; in_valid = 1'b0; memfetch = 1'b0; memstore = 1'b0;
        result = 32'h0; rd = 5'd0; store_data = 32'h0; funct3 = 3'b000;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_ready", in_ready, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk32("rst_addr", mem_addr, 32'h0);
        chk32("rst_wdata", mem_wdata, 32'h0);
        chk32("rst_strb", {28'h0, mem_wstrb}, 32'h0);
        chk1("rst_wb_en", wb_en, 1'b0);
        chk32("rst_wb_data", wb_data, 32'h0);
        chk32("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
`ifdef RISCV_MISALIGN_TRAP_EN
        chk1("rst_misalign", misalign, 1'b0);
`endif
        rst_n = 1'b1;
        #1;
        chk1("ready_after_rst", in_ready, 1'b1);

        // Back-to-back ALU ops, including a write to x0
        for (int i = 0; i < 4; i++) begin
            logic [31:0] alu_res[4];
            logic [4:0]  alu_rd[4];
            alu_res = '{32'h1234, 32'hAAAA_0001, 32'hFFFF_FFFF, 32'h0};
            alu_rd  = '{5'd5, 5'd7, 5'd0, 5'd31};
            in_valid = 1'b1; result = alu_res[i]; rd = alu_rd[i];
            @(posedge clk); #1;
            chk1("alu_wb_en", wb_en, alu_rd[i] != 5'd0);
            if (alu_rd[i] != 5'd0) begin
                chk32("alu_wb_rd", {27'h0, wb_rd}, {27'h0, alu_rd[i]});
                chk32("alu_wb_data", wb_data, alu_res[i]);
            end
            chk1("alu_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk1("alu_idle_nowb", wb_en, 1'b0);

        // Directed load/store table
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of an access; a late ack must be ignored
        wait_ready();
        in_valid = 1'b1; memfetch = 1'b1; funct3 = 3'b010; result = 32'h40; rd = 5'd8;
        @(posedge clk); #1;
        in_valid = 1'b0; memfetch = 1'b0;
        chk1("mid_req", mem_req, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk1("mid_rst_req", mem_req, 1'b0);
        chk1("mid_rst_wb", wb_en, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b0);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk1("late_ack_req", mem_req, 1'b0);
        chk1("late_ack_wb", wb_en, 1'b0);
        chk1("late_ack_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk1("late_ack_wb2", wb_en, 1'b0);

        // Misaligned addresses
`ifdef RISCV_MISALIGN_TRAP_EN
        in_valid = 1'b1; memfetch = 1'b1; funct3 = 3'b010; result = 32'h102; rd = 5'd6;
        @(posedge clk); #1;
        in_valid = 1'b0; memfetch = 1'b0;
        chk1("mis_flag", misalign, 1'b1);
        chk1("mis_req", mem_req, 1'b0);
        chk1("mis_wb", wb_en, 1'b0);
        chk1("mis_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk1("mis_flag_pulse", misalign, 1'b0);
        chk1("mis_req2", mem_req, 1'b0);
        chk1("mis_wb2", wb_en, 1'b0);
`else
        xv = '{1'b1, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 5'd6, 1, 32'h100, 4'b1111, 32'h0, 32'h1122_3344};
        run_vec(xv);
        xv = '{1'b1, 3'b001, 32'h203, 32'h0, 32'h8001_0000, 5'd7, 2, 32'h200, 4'b1100, 32'h0, 32'hFFFF_8001};
        run_vec(xv);
`endif

        // Randomized run against the transaction-level model
        wait_ready();
        @(posedge clk); #1;
        req_e = 1'b0; rdy_e = 1'b1; cnt = 0; cur = '{1'b0, 3'b000, 32'h0, 32'h0, 5'd0};
        chk1("rnd_start_ready", in_ready, 1'b1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            v_s  = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 2);
            nop.ld  = (kind == 1);
            nop.f3  = 3'($urandom_range(0, 7));
            nop.res = $urandom;
            nop.sd  = $urandom;
            nop.rdi = 5'($urandom_range(0, 7));
`ifdef RISCV_MISALIGN_TRAP_EN
            nop.res = nop.res - (nop.res % 32'(size_of(nop.f3)));
`endif
            if (req_e && cnt == 0) ack_s = 1'b1;
            else if (!req_e) ack_s = ($urandom_range(0, 4) == 0);
            else ack_s = 1'b0;
            rdata_s = $urandom;

            in_valid = v_s; memfetch = (kind == 1); memstore = (kind == 2);
            funct3 = nop.f3; result = nop.res; store_data = nop.sd; rd = nop.rdi;
            mem_ack = ack_s; mem_rdata = rdata_s;

            accept  = rdy_e && v_s;
            wbcycle = req_e && ack_s && cur.ld;
            wb_n = 1'b0; wbrd_n = 5'd0; wbd_n = 32'h0;
            if (accept && kind == 0) begin
                wb_n = (nop.rdi != 5'd0); wbrd_n = nop.rdi; wbd_n = nop.res;
            end
            if (wbcycle) begin
                wb_n = (cur.rdi != 5'd0); wbrd_n = cur.rdi;
                wbd_n = ref_load(cur.f3, cur.res, rdata_s);
            end
            req_n = (accept && kind != 0) || (req_e && !ack_s);
            if (accept && kind != 0) begin
                cur = nop;
                cnt = $urandom_range(0, 4);
            end else if (req_e && !ack_s) begin
                cnt--;
            end
            rdy_n = !req_n && !wbcycle;

            @(posedge clk); #1;
            chk1("rnd_wb_en", wb_en, wb_n);
            if (wb_n) begin
                chk32("rnd_wb_rd", {27'h0, wb_rd}, {27'h0, wbrd_n});
                chk32("rnd_wb_data", wb_data, wbd_n);
            end
            chk1("rnd_req", mem_req, req_n);
            if (req_n) begin
                chk32("rnd_addr", mem_addr, cur.res & 32'hFFFF_FFFC);
                chk1("rnd_we", mem_we, !cur.ld);
                chk32("rnd_strb", {28'h0, mem_wstrb}, {28'h0, ref_strb(cur.f3, cur.res)});
                if (!cur.ld) chk32("rnd_wdata", mem_wdata, ref_wdata(cur.f3, cur.sd));
            end
            chk1("rnd_ready", in_ready, rdy_n);
`ifdef RISCV_MISALIGN_TRAP_EN
            chk1("rnd_misalign", misalign, 1'b0);
`endif
            req_e = req_n; rdy_e = rdy_n;
        end
        in_valid = 1'b0; mem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
